// File: rtl/irq_controller_param.sv
// irq_controller_param
//   Parametrised interrupt controller. N_SRC rising-edge-latched sources are
//   each mapped (GRP_MAP) to one of N_GRP groups carrying a PRIO_W-bit
//   software priority. Sources below N_NMI ignore the enable mask and always
//   arbitrate at the top level. The highest-priority pending source (lowest
//   index on ties) drives a one-hot cpu_irq level and supplies its vector on
//   the CPU acknowledge cycle.
//
//   Register bytes from BASE_ADDR: PRIO (P bytes), ENA (E bytes),
//   ACT (E bytes, write-1-to-clear).
//
// Ports
//   clk, reset      clock; asynchronous active-high reset
//   bus_write       single-cycle write strobe (bus_address_in, bus_data_in)
//   bus_read        read strobe; reads are side-effect free
//   bus_data_out    register byte, or winner vector while cpu_iack is high
//   irqs            raw source requests, rising edge latched into ACT
//   cpu_iack        one-cycle acknowledge; latches irq_vector
//   cpu_irq         registered one-hot request level (bit 0 never set)
//   irq_vector      registered vector {src[5],1'b0,src[4:0],1'b0}
module irq_controller_param #(
  parameter int              N_SRC     = 32,
  parameter int              N_GRP     = 9,
  parameter int              PRIO_W    = 2,
  parameter int              N_NMI     = 3,
  parameter logic [4*N_SRC-1:0] GRP_MAP = '0,
  parameter logic [23:0]     BASE_ADDR = 24'h2020,
  parameter bit              AUTO_CLR  = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   bus_write,
  input  logic                   bus_read,
  input  logic [23:0]            bus_address_in,
  input  logic [7:0]             bus_data_in,
  output logic [7:0]             bus_data_out,
  input  logic [N_SRC-1:0]       irqs,
  input  logic                   cpu_iack,
  output logic [2**PRIO_W-1:0]   cpu_irq,
  output logic [7:0]             irq_vector
);

  localparam int PBITS = N_GRP * PRIO_W;
  localparam int P     = (PBITS + 7) / 8;
  localparam int E     = N_SRC / 8;
  localparam int NB    = P + 2 * E;

  typedef enum logic {S_IDLE, S_ACK} ack_state_t;

  ack_state_t              state_q, state_d;
  logic [PBITS-1:0]        prio_q, prio_d;
  logic [N_SRC-1:0]        ena_q, ena_d;
  logic [N_SRC-1:0]        act_q, act_d, act_clr, rise;
  logic [N_SRC-1:0]        irqs_q;

  logic [23:0]             off;
  logic [NB-1:0]           wr_byte;
  logic [P*8-1:0]          prio_pad;
  logic [NB*8-1:0]         map_flat;
  logic [7:0]              rd_byte;

  logic                    win_vld;
  logic [5:0]              win_idx;
  logic [PRIO_W-1:0]       win_prio;
  logic [7:0]              win_vec;
  logic [2**PRIO_W-1:0]    lvl_onehot;
  logic                    ack_take;

  logic                    cand;
  int                      grp_sel;
  logic [PRIO_W-1:0]       eff_prio;

  // Reads have no side effects, so the read strobe carries no information.
  logic unused_read;
  assign unused_read = bus_read;

  // Addresses below BASE_ADDR wrap to large offsets and so never decode.
  assign off = bus_address_in - BASE_ADDR;

  always_comb begin
    for (int k = 0; k < NB; k++) begin
      wr_byte[k] = bus_write && (off == 24'(k));
    end
  end

  // Arbitration on registered state: strict '>' over ascending indices keeps
  // the lowest index on ties, and a zero priority can never beat the start
  // value so it never wins.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    win_prio = '0;
    cand     = 1'b0;
    grp_sel  = 0;
    eff_prio = '0;
    for (int i = 0; i < N_SRC; i++) begin
      cand    = act_q[i] && (ena_q[i] || (i < N_NMI));
      grp_sel = int'(GRP_MAP[4*i +: 4]);
      if (i < N_NMI) begin
        eff_prio = '1;
      end else if (grp_sel < N_GRP) begin
        eff_prio = prio_q[grp_sel*PRIO_W +: PRIO_W];
      end else begin
        eff_prio = '0;
      end
      if (cand && (eff_prio > win_prio)) begin
        win_vld  = 1'b1;
        win_idx  = 6'(i);
        win_prio = eff_prio;
      end
    end
  end

  assign win_vec = win_vld ? {win_idx[5], 1'b0, win_idx[4:0], 1'b0} : 8'd0;

  always_comb begin
    lvl_onehot = '0;
    if (win_vld) begin
      lvl_onehot[win_prio] = 1'b1;
    end
  end

  // Acknowledge FSM: ACK lasts one cycle so a held cpu_iack cannot
  // acknowledge twice.
  always_comb begin
    state_d  = state_q;
    ack_take = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_iack) begin
          ack_take = 1'b1;
          state_d  = S_ACK;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Register file next-state. A new rising edge is OR-ed in last so it wins
  // over both the W1C clear and the acknowledge auto-clear.
  always_comb begin
    prio_d  = prio_q;
    ena_d   = ena_q;
    act_clr = '0;
    for (int j = 0; j < PBITS; j++) begin
      if (wr_byte[j/8]) begin
        prio_d[j] = bus_data_in[j%8];
      end
    end
    for (int k = 0; k < E; k++) begin
      if (wr_byte[P+k]) begin
        ena_d[8*k +: 8] = bus_data_in;
      end
      if (wr_byte[P+E+k]) begin
        act_clr[8*k +: 8] = bus_data_in;
      end
    end
    if (AUTO_CLR && ack_take && win_vld) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (win_idx == 6'(i)) begin
          act_clr[i] = 1'b1;
        end
      end
    end
    rise  = irqs & ~irqs_q;
    act_d = (act_q & ~act_clr) | rise;
  end

  // Read mux; PRIO padding bits read as zero.
  always_comb begin
    prio_pad              = '0;
    prio_pad[PBITS-1:0]   = prio_q;
    map_flat              = {act_q, ena_q, prio_pad};
    rd_byte               = 8'd0;
    for (int k = 0; k < NB; k++) begin
      if (off == 24'(k)) begin
        rd_byte = map_flat[8*k +: 8];
      end
    end
    bus_data_out = cpu_iack ? win_vec : rd_byte;
  end

  // Stage boundary: all state updates on the rising edge. cpu_irq is loaded
  // with zero when entering ACK so the stale level is dropped during the
  // acknowledge cycle, then reloaded from the post-clear winner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      prio_q     <= '0;
      ena_q      <= '0;
      act_q      <= '0;
      irqs_q     <= '0;
      cpu_irq    <= '0;
      irq_vector <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      ena_q   <= ena_d;
      act_q   <= act_d;
      irqs_q  <= irqs;
      cpu_irq <= (state_d == S_ACK) ? '0 : lvl_onehot;
      if (ack_take) begin
        irq_vector <= win_vec;
      end
    end
  end

endmodule

// File: tb/tb_irq_controller_param.sv
module tb_irq_controller_param;

  localparam int N_SRC = 32;
  localparam int N_GRP = 9;
  localparam int N_NMI = 3;
  localparam logic [23:0] BASE = 24'h2020;
  localparam int P = 3;
  localparam int E = 4;
  localparam int NB = 11;
  localparam int OFF_ENA = 3;
  localparam int OFF_ACT = 7;

  function automatic logic [4*N_SRC-1:0] mk_map();
    logic [4*N_SRC-1:0] m;
    m = '0;
    for (int i = 0; i < N_SRC; i++) m[4*i +: 4] = 4'(i % N_GRP);
    m[4*4 +: 4] = 4'd3;
    m[4*7 +: 4] = 4'd1;
    return m;
  endfunction

  localparam logic [4*N_SRC-1:0] MAP = mk_map();

  logic        clk;
  logic        reset;
  logic        bus_write;
  logic        bus_read;
  logic [23:0] bus_address_in;
  logic [7:0]  bus_data_in;
  logic [7:0]  bus_data_out;
  logic [N_SRC-1:0] irqs;
  logic        cpu_iack;
  logic [3:0]  cpu_irq;
  logic [7:0]  irq_vector;

  int checks = 0;
  int errors = 0;

  irq_controller_param #(
    .N_SRC(32), .N_GRP(9), .PRIO_W(2), .N_NMI(3),
    .GRP_MAP(MAP), .BASE_ADDR(24'h2020), .AUTO_CLR(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .bus_write(bus_write), .bus_read(bus_read),
    .bus_address_in(bus_address_in), .bus_data_in(bus_data_in),
    .bus_data_out(bus_data_out), .irqs(irqs), .cpu_iack(cpu_iack),
    .cpu_irq(cpu_irq), .irq_vector(irq_vector)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_prio[N_GRP];
  logic [31:0] m_ena, m_act, m_prev;
  logic [3:0]  m_irq;
  logic [7:0]  m_vec;
  bit          m_ack;

  task automatic model_reset();
    for (int g = 0; g < N_GRP; g++) m_prio[g] = 0;
    m_ena = '0; m_act = '0; m_prev = '0;
    m_irq = '0; m_vec = '0; m_ack = 1'b0;
  endtask

  function automatic int m_eff(int i);
    if (i < N_NMI) return 3;
    return m_prio[MAP[4*i +: 4]];
  endfunction

  function automatic bit m_elig(int i);
    return m_act[i] && (m_ena[i] || (i < N_NMI));
  endfunction

  function automatic void m_winner(output bit vld, output int idx, output int pr);
    int best;
    best = 0;
    for (int i = 0; i < N_SRC; i++)
      if (m_elig(i) && m_eff(i) > best) best = m_eff(i);
    vld = (best > 0);
    pr = best;
    idx = 0;
    if (vld)
      for (int i = N_SRC - 1; i >= 0; i--)
        if (m_elig(i) && m_eff(i) == best) idx = i;
  endfunction

  function automatic logic [7:0] m_read(input logic [23:0] a, input bit iack);
    bit vld; int idx, pr, off;
    logic [23:0] pw;
    m_winner(vld, idx, pr);
    if (iack) return vld ? 8'(idx * 2) : 8'h00;
    off = int'(a - BASE);
    pw = '0;
    for (int g = 0; g < N_GRP; g++) pw[2*g +: 2] = 2'(m_prio[g]);
    if (off < P) return pw[8*off +: 8];
    if (off < P + E) return m_ena[8*(off-P) +: 8];
    if (off < NB) return m_act[8*(off-P-E) +: 8];
    return 8'h00;
  endfunction

  task automatic model_step();
    bit vld, take; int idx, pr, off;
    logic [23:0] pw;
    logic [31:0] clr;
    m_winner(vld, idx, pr);
    take = !m_ack && cpu_iack;
    off = int'(bus_address_in - BASE);
    clr = '0;
    pw = '0;
    for (int g = 0; g < N_GRP; g++) pw[2*g +: 2] = 2'(m_prio[g]);
    if (bus_write) begin
      if (off < P) begin
        pw[8*off +: 8] = bus_data_in;
        for (int g = 0; g < N_GRP; g++) m_prio[g] = int'(pw[2*g +: 2]);
      end else if (off < P + E) begin
        m_ena[8*(off-P) +: 8] = bus_data_in;
      end else if (off < NB) begin
        clr[8*(off-P-E) +: 8] = bus_data_in;
      end
    end
    if (take && vld) clr[idx] = 1'b1;
    m_act = (m_act & ~clr) | (irqs & ~m_prev);
    if (take) m_vec = vld ? 8'(idx * 2) : 8'h00;
    m_irq = (take || !vld) ? 4'h0 : 4'(1 << pr);
    m_ack = take;
    m_prev = irqs;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input int off, input logic [7:0] d);
    bus_write = 1'b1;
    bus_address_in = BASE + 24'(off);
    bus_data_in = d;
    cycle();
    bus_write = 1'b0;
  endtask

  task automatic rd_set(input int off);
    bus_address_in = BASE + 24'(off);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; bus_write = 1'b0; bus_read = 1'b0; cpu_iack = 1'b0;
    bus_address_in = '0; bus_data_in = '0; irqs = '0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (cpu_irq !== 4'h0 || irq_vector !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs cpu_irq=%h vec=%h want 0/00", cpu_irq, irq_vector);
    end
    reset = 1'b0;
    bus_read = 1'b1;
    for (int k = 0; k < NB + 2; k++) begin
      rd_set(k);
      checks++;
      if (bus_data_out !== 8'h00) begin
        errors++;
        $display("FAIL reset_read off=%0d got=%h want=00", k, bus_data_out);
      end
    end
  endtask

  task automatic test_prio_group();
    wr(0, 8'h80);
    wr(OFF_ENA, 8'h10);
    irqs[4] = 1'b1;
    cycle();
    irqs[4] = 1'b0;
    rd_set(OFF_ACT);
    checks++;
    if (bus_data_out !== 8'h10) begin
      errors++; $display("FAIL grp_act got=%h want=10", bus_data_out);
    end
    checks++;
    if (cpu_irq !== 4'h0) begin
      errors++; $display("FAIL grp_latency cpu_irq=%b want=0000", cpu_irq);
    end
    cycle();
    checks++;
    if (cpu_irq !== 4'b0100) begin
      errors++; $display("FAIL grp_level cpu_irq=%b want=0100", cpu_irq);
    end
    rd_set(0);
    checks++;
    if (bus_data_out !== 8'h80) begin
      errors++; $display("FAIL grp_prio_read got=%h want=80", bus_data_out);
    end
  endtask

  task automatic test_two_sources();
    wr(0, 8'h8C);
    wr(OFF_ENA, 8'h90);
    irqs[7] = 1'b1;
    cycle();
    irqs[7] = 1'b0;
    cycle();
    checks++;
    if (cpu_irq !== 4'b1000) begin
      errors++; $display("FAIL two_level cpu_irq=%b want=1000", cpu_irq);
    end
    cpu_iack = 1'b1;
    rd_set(OFF_ACT);
    checks++;
    if (bus_data_out !== 8'h0E) begin
      errors++; $display("FAIL two_iack_bus got=%h want=0E", bus_data_out);
    end
    cycle();
    cpu_iack = 1'b0;
    checks++;
    if (irq_vector !== 8'h0E) begin
      errors++; $display("FAIL two_vector got=%h want=0E", irq_vector);
    end
    checks++;
    if (cpu_irq !== 4'h0) begin
      errors++; $display("FAIL two_ack_quiet cpu_irq=%b want=0000", cpu_irq);
    end
    rd_set(OFF_ACT);
    checks++;
    if (bus_data_out !== 8'h10) begin
      errors++; $display("FAIL two_autoclr act=%h want=10", bus_data_out);
    end
    cycle();
    checks++;
    if (cpu_irq !== 4'b0100) begin
      errors++; $display("FAIL two_rerequest cpu_irq=%b want=0100", cpu_irq);
    end
  endtask

  task automatic test_nmi();
    wr(0, 8'h00); wr(1, 8'h00); wr(2, 8'h00);
    wr(OFF_ENA, 8'h00);
    wr(OFF_ACT, 8'hFF);
    checks++;
    if (cpu_irq !== 4'h0) begin
      errors++; $display("FAIL nmi_idle cpu_irq=%b want=0000", cpu_irq);
    end
    irqs[0] = 1'b1;
    cycle();
    irqs[0] = 1'b0;
    cycle();
    checks++;
    if (cpu_irq !== 4'b1000) begin
      errors++; $display("FAIL nmi_level cpu_irq=%b want=1000", cpu_irq);
    end
    cpu_iack = 1'b1;
    rd_set(OFF_ACT);
    checks++;
    if (bus_data_out !== 8'h00) begin
      errors++; $display("FAIL nmi_iack_bus got=%h want=00", bus_data_out);
    end
    cycle();
    cpu_iack = 1'b0;
    checks++;
    if (irq_vector !== 8'h00) begin
      errors++; $display("FAIL nmi_vector got=%h want=00", irq_vector);
    end
    rd_set(OFF_ACT);
    checks++;
    if (bus_data_out !== 8'h00) begin
      errors++; $display("FAIL nmi_autoclr act=%h want=00", bus_data_out);
    end
  endtask

  task automatic test_set_wins();
    wr(OFF_ENA, 8'h10);
    wr(0, 8'h80);
    irqs[4] = 1'b1;
    cycle();
    irqs[4] = 1'b0;
    cycle();
    bus_write = 1'b1;
    bus_address_in = BASE + 24'(OFF_ACT);
    bus_data_in = 8'h10;
    irqs[4] = 1'b1;
    cycle();
    bus_write = 1'b0;
    irqs[4] = 1'b0;
    rd_set(OFF_ACT);
    checks++;
    if (bus_data_out !== 8'h10) begin
      errors++; $display("FAIL setwins act=%h want=10", bus_data_out);
    end
    cycle();
    wr(OFF_ACT, 8'h10);
    rd_set(OFF_ACT);
    checks++;
    if (bus_data_out !== 8'h00) begin
      errors++; $display("FAIL w1c_plain act=%h want=00", bus_data_out);
    end
  endtask

  task automatic test_hold_no_relatch();
    irqs[5] = 1'b1;
    cycle();
    rd_set(OFF_ACT);
    checks++;
    if (bus_data_out !== 8'h20) begin
      errors++; $display("FAIL hold_latch act=%h want=20", bus_data_out);
    end
    wr(OFF_ACT, 8'h20);
    repeat (10) cycle();
    rd_set(OFF_ACT);
    checks++;
    if (bus_data_out !== 8'h00) begin
      errors++; $display("FAIL hold_relatch act=%h want=00", bus_data_out);
    end
    irqs[5] = 1'b0;
    cycle();
    irqs[5] = 1'b1;
    cycle();
    rd_set(OFF_ACT);
    checks++;
    if (bus_data_out !== 8'h20) begin
      errors++; $display("FAIL hold_newedge act=%h want=20", bus_data_out);
    end
    irqs[5] = 1'b0;
    wr(OFF_ACT, 8'h20);
  endtask

  task automatic test_map_bounds();
    logic [7:0] exp;
    wr(2, 8'hFF);
    rd_set(2);
    checks++;
    if (bus_data_out !== 8'h03) begin
      errors++; $display("FAIL prio_pad got=%h want=03", bus_data_out);
    end
    wr(NB, 8'hFF);
    wr(-1, 8'hFF);
    rd_set(NB);
    checks++;
    if (bus_data_out !== 8'h00) begin
      errors++; $display("FAIL out_of_map_read got=%h want=00", bus_data_out);
    end
    for (int k = 0; k < NB; k++) begin
      rd_set(k);
      exp = m_read(bus_address_in, 1'b0);
      checks++;
      if (bus_data_out !== exp) begin
        errors++; $display("FAIL bounds_map off=%0d got=%h want=%h", k, bus_data_out, exp);
      end
    end
    wr(2, 8'h00);
  endtask

  task automatic test_reset_mid_ack();
    irqs[1] = 1'b1;
    cycle();
    irqs[1] = 1'b0;
    cycle();
    checks++;
    if (cpu_irq !== 4'b1000) begin
      errors++; $display("FAIL rstack_level cpu_irq=%b want=1000", cpu_irq);
    end
    cpu_iack = 1'b1;
    cycle();
    cpu_iack = 1'b0;
    checks++;
    if (irq_vector !== 8'h02) begin
      errors++; $display("FAIL rstack_vector got=%h want=02", irq_vector);
    end
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (irq_vector !== 8'h00 || cpu_irq !== 4'h0) begin
      errors++; $display("FAIL rstack_async vec=%h cpu_irq=%b want 00/0000", irq_vector, cpu_irq);
    end
    rd_set(0);
    checks++;
    if (bus_data_out !== 8'h00) begin
      errors++; $display("FAIL rstack_prio got=%h want=00", bus_data_out);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] exp;
    for (int n = 0; n < 400; n++) begin
      cpu_iack = ($urandom_range(0, 5) == 0);
      bus_write = ($urandom_range(0, 3) == 0);
      bus_address_in = BASE + 24'($urandom_range(0, NB));
      bus_data_in = 8'($urandom);
      irqs = irqs ^ ($urandom & $urandom & $urandom);
      #1;
      exp = m_read(bus_address_in, cpu_iack);
      checks++;
      if (bus_data_out !== exp) begin
        errors++; $display("FAIL rnd_bus n=%0d got=%h want=%h", n, bus_data_out, exp);
      end
      checks++;
      if (cpu_irq !== m_irq) begin
        errors++; $display("FAIL rnd_cpu_irq n=%0d got=%b want=%b", n, cpu_irq, m_irq);
      end
      checks++;
      if (irq_vector !== m_vec) begin
        errors++; $display("FAIL rnd_vector n=%0d got=%h want=%h", n, irq_vector, m_vec);
      end
      cycle();
    end
    cpu_iack = 1'b0;
    bus_write = 1'b0;
  endtask

  initial begin
    test_reset();
    test_prio_group();
    test_two_sources();
    test_nmi();
    test_set_wins();
    test_hold_no_relatch();
    test_map_bounds();
    test_reset_mid_ack();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
